mdu_div_ctrl: RTL

MDU_DIV_CTRL -- requirements
Module: mdu_div_ctrl

---
 rtl/mdu_div_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl -- iterative 32-bit divider with pipeline handshake.
//
// Purpose: executes DIV/DIVU/REM/REMU requests from the ID/EX stage using
// a 32-cycle restoring division. Divide-by-zero and signed overflow are
// resolved without iterating.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst_n            synchronous reset, ACTIVE-HIGH despite the name
//   idex_div_start_i divide request, sampled only in IDLE
//   idex_div_op_i    00 DIV, 01 DIVU, 10 REM, 11 REMU
//   idex_op_a_i      dividend
//   idex_op_b_i      divisor
//   idex_reg_waddr_i destination register, captured with the start
//   fc_flush_i       kill from the flow controller, forces IDLE
//   div_stall_req_o  holds the pipeline while a divide is in progress
//   div_busy_o       high whenever the FSM is not IDLE
//   div_valid_o      one-cycle pulse, result valid
//   div_result_o     quotient or remainder, held until the next DONE
//   div_reg_waddr_o  destination register belonging to div_result_o
module mdu_div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_div_start_i,
  input  logic [1:0]  idex_div_op_i,
  input  logic [31:0] idex_op_a_i,
  input  logic [31:0] idex_op_b_i,
  input  logic [4:0]  idex_reg_waddr_i,
  input  logic        fc_flush_i,
  output logic        div_stall_req_o,
  output logic        div_busy_o,
  output logic        div_valid_o,
  output logic [31:0] div_result_o,
  output logic [4:0]  div_reg_waddr_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rem_op_q, rem_op_d;    // 1: return remainder
  logic        neg_quo_q, neg_quo_d;  // negate quotient at the end
  logic        neg_rem_q, neg_rem_d;  // negate remainder at the end
  logic [31:0] quo_q, quo_d;          // dividend shifts out, quotient shifts in
  logic [32:0] rem_q, rem_d;          // partial remainder
  logic [31:0] dvs_q, dvs_d;          // magnitude of the divisor
  logic [4:0]  cap_waddr_q, cap_waddr_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  waddr_q, waddr_d;

  logic        start_ok;
  logic        signed_op;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic        ovf;
  logic [32:0] rem_sh, diff, rem_nx;
  logic        qbit;
  logic [31:0] quo_nx, quo_fix, rem_fix;

  always_comb begin
    start_ok  = idex_div_start_i & ~fc_flush_i;
    signed_op = ~idex_div_op_i[0];
    a_neg     = signed_op & idex_op_a_i[31];
    b_neg     = signed_op & idex_op_b_i[31];
    abs_a     = a_neg ? (~idex_op_a_i + 32'd1) : idex_op_a_i;
    abs_b     = b_neg ? (~idex_op_b_i + 32'd1) : idex_op_b_i;
    ovf       = signed_op && (idex_op_a_i == 32'h8000_0000) &&
                (idex_op_b_i == 32'hFFFF_FFFF);

    // One restoring step: shift the next dividend bit into the remainder,
    // keep the subtraction only if it did not go negative.
    rem_sh  = {rem_q[31:0], quo_q[31]};
    diff    = rem_sh - {1'b0, dvs_q};
    qbit    = ~diff[32];
    rem_nx  = qbit ? diff : rem_sh;
    quo_nx  = {quo_q[30:0], qbit};
    quo_fix = neg_quo_q ? (~quo_nx + 32'd1) : quo_nx;
    rem_fix = neg_rem_q ? (~rem_nx[31:0] + 32'd1) : rem_nx[31:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_op_d    = rem_op_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cap_waddr_d = cap_waddr_q;
    result_d    = result_q;
    waddr_d     = waddr_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          rem_op_d    = idex_div_op_i[1];
          cap_waddr_d = idex_reg_waddr_i;
          if (idex_op_b_i == '0) begin
            result_d = idex_div_op_i[1] ? idex_op_a_i : '1;
            waddr_d  = idex_reg_waddr_i;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = idex_div_op_i[1] ? '0 : 32'h8000_0000;
            waddr_d  = idex_reg_waddr_i;
            state_d  = DONE;
          end else begin
            quo_d     = abs_a;
            rem_d     = '0;
            dvs_d     = abs_b;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          // Sign fix-up is folded into the final step so the result
          // register is already correct in the DONE cycle.
          result_d = rem_op_q ? rem_fix : quo_fix;
          waddr_d  = cap_waddr_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush abandons the operation and leaves the visible result untouched.
    if (fc_flush_i) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
      waddr_d  = waddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_op_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cap_waddr_q <= '0;
      result_q    <= '0;
      waddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_op_q    <= rem_op_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cap_waddr_q <= cap_waddr_d;
      result_q    <= result_d;
      waddr_q     <= waddr_d;
    end
  end

  always_comb begin
    div_stall_req_o = ~rst_n & (((state_q == IDLE) & start_ok) | (state_q == CALC));
    div_busy_o      = (state_q != IDLE);
    div_valid_o     = ~rst_n & ~fc_flush_i & (state_q == DONE);
    div_result_o    = result_q;
    div_reg_waddr_o = waddr_q;
  end

endmodule
